counter_inc_scheduler: RTL and testbench

//  Controller and arbiter for the 4-bit increment counter datapath (v / imp pair, en + load-on-rst).

---
 rtl/counter_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/counter_inc_scheduler.sv | 165 ++++++++++++++++
 tb/tb_counter_inc_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and default sizing for the increment-counter scheduler.
package counter_sched_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_INC  = 2'd3
  } sched_state_e;

  // Index width that stays legal for any requester count >= 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_REQ,
  parameter int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand_s;
  logic          found_s;

  // First requester after the pointer wins; the pointer's own slot is visited last.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= int'(N); i++) begin
      cand_s = PW'((int'(ptr) + i) % int'(N));
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/counter_inc_scheduler.sv
// Arbitrates increments to a 4-bit counter datapath, sequences loads, and
// cross-checks the datapath against a shadow copy.
module counter_inc_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic [WIDTH-1:0]   load_val,
  output logic               load_ack,
  input  logic [NUM_REQ-1:0] inc_req,
  output logic [NUM_REQ-1:0] inc_gnt,
  output logic               ctr_rst,
  output logic [WIDTH-1:0]   ctr_ui,
  output logic               ctr_en,
  input  logic [WIDTH-1:0]   ctr_out,
  output logic [WIDTH-1:0]   shadow_v,
  output logic [CNT_W-1:0]   grant_cnt,
  output logic               busy,
  output logic               mismatch,
  input  logic               clr_err
);

  localparam int unsigned PW = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sched_state_e        state_r;
  logic [PW-1:0]       ptr_r;
  logic [WIDTH-1:0]    load_val_r;
  logic [WIDTH-1:0]    shadow_v_r;
  logic [CNT_W-1:0]    grant_cnt_r;
  logic                mismatch_r;
  logic                load_ack_r;
  logic [NUM_REQ-1:0]  inc_gnt_r;
  logic                ctr_rst_r;
  logic [WIDTH-1:0]    ctr_ui_r;
  logic                ctr_en_r;
  logic                busy_r;

  logic [NUM_REQ-1:0]  arb_gnt_s;
  logic                arb_any_s;
  logic [PW-1:0]       arb_idx_s;
  logic                take_load_s;
  logic                take_inc_s;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req (inc_req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .any (arb_any_s),
    .idx (arb_idx_s)
  );

  // Next-operation decision; LOAD also decides so a request held across a load is granted right after it.
  always_comb begin
    take_load_s = 1'b0;
    take_inc_s  = 1'b0;
    if (state_r == ST_INIT) begin
      take_load_s = 1'b0;
      take_inc_s  = 1'b0;
    end else if (load_req) begin
      take_load_s = 1'b1;
    end else if (arb_any_s) begin
      take_inc_s = 1'b1;
    end else begin
      take_inc_s = 1'b0;
    end
  end

  // FSM with registered datapath strobes; the pointer moves on the grant decision so back-to-back INC rotates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      ptr_r      <= PW'(NUM_REQ - 1);
      load_val_r <= '0;
      load_ack_r <= 1'b0;
      inc_gnt_r  <= '0;
      ctr_rst_r  <= 1'b1;
      ctr_ui_r   <= '0;
      ctr_en_r   <= 1'b0;
      busy_r     <= 1'b1;
    end else if (take_load_s) begin
      state_r    <= ST_LOAD;
      load_val_r <= load_val;
      load_ack_r <= 1'b1;
      inc_gnt_r  <= '0;
      ctr_rst_r  <= 1'b1;
      ctr_ui_r   <= load_val;
      ctr_en_r   <= 1'b0;
      busy_r     <= 1'b1;
    end else if (take_inc_s) begin
      state_r    <= ST_INC;
      ptr_r      <= arb_idx_s;
      load_ack_r <= 1'b0;
      inc_gnt_r  <= arb_gnt_s;
      ctr_rst_r  <= 1'b0;
      ctr_ui_r   <= '0;
      ctr_en_r   <= 1'b1;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= ST_IDLE;
      load_ack_r <= 1'b0;
      inc_gnt_r  <= '0;
      ctr_rst_r  <= 1'b0;
      ctr_ui_r   <= '0;
      ctr_en_r   <= 1'b0;
      busy_r     <= 1'b0;
    end
  end

  // Shadow value and grant counter follow the datapath on the edge that ends each operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_v_r  <= '0;
      grant_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          shadow_v_r  <= '0;
          grant_cnt_r <= grant_cnt_r;
        end
        ST_LOAD: begin
          shadow_v_r  <= load_val_r;
          grant_cnt_r <= '0;
        end
        ST_INC: begin
          shadow_v_r  <= shadow_v_r + WIDTH'(1);
          grant_cnt_r <= (grant_cnt_r == CNT_MAX) ? grant_cnt_r : grant_cnt_r + CNT_W'(1);
        end
        default: begin
          shadow_v_r  <= shadow_v_r;
          grant_cnt_r <= grant_cnt_r;
        end
      endcase
    end
  end

  // Sticky compare error; a fresh miscompare beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= 1'b0;
    end else if ((state_r != ST_INIT) && (ctr_out != shadow_v_r)) begin
      mismatch_r <= 1'b1;
    end else if (clr_err) begin
      mismatch_r <= 1'b0;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign load_ack  = load_ack_r;
  assign inc_gnt   = inc_gnt_r;
  assign ctr_rst   = ctr_rst_r;
  assign ctr_ui    = ctr_ui_r;
  assign ctr_en    = ctr_en_r;
  assign shadow_v  = shadow_v_r;
  assign grant_cnt = grant_cnt_r;
  assign busy      = busy_r;
  assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_counter_inc_scheduler.sv
// Directed, table-driven bench for counter_inc_scheduler with a behavioural counter datapath.
module tb_counter_inc_scheduler;

  logic       clk;
  logic       rst;
  logic       load_req;
  logic [3:0] load_val;
  logic       load_ack;
  logic [3:0] inc_req;
  logic [3:0] inc_gnt;
  logic       ctr_rst;
  logic [3:0] ctr_ui;
  logic       ctr_en;
  logic [3:0] ctr_out;
  logic [3:0] shadow_v;
  logic [7:0] grant_cnt;
  logic       busy;
  logic       mismatch;
  logic       clr_err;

  logic [3:0] dp_v;
  logic       force_en;
  logic [3:0] force_val;

  int checks;
  int errors;

  typedef struct {
    logic       r;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] req;
    logic       clr;
    logic [3:0] gnt;
    logic       en;
    logic       crst;
    logic [3:0] ui;
    logic       ack;
    logic       bsy;
    logic [3:0] sh;
    logic [7:0] cnt;
    logic       mis;
  } vec_t;

  vec_t tbl[$];

  counter_inc_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .load_val  (load_val),
    .load_ack  (load_ack),
    .inc_req   (inc_req),
    .inc_gnt   (inc_gnt),
    .ctr_rst   (ctr_rst),
    .ctr_ui    (ctr_ui),
    .ctr_en    (ctr_en),
    .ctr_out   (ctr_out),
    .shadow_v  (shadow_v),
    .grant_cnt (grant_cnt),
    .busy      (busy),
    .mismatch  (mismatch),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath: load strobe wins over increment.
  always @(posedge clk) begin
    if (ctr_rst) dp_v <= ctr_ui;
    else if (ctr_en) dp_v <= dp_v + 4'd1;
  end

  assign ctr_out = force_en ? force_val : dp_v;

  function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] lv,
                              input logic [3:0] req, input logic clr, input logic [3:0] gnt,
                              input logic en, input logic crst, input logic [3:0] ui,
                              input logic ack, input logic bsy, input logic [3:0] sh,
                              input logic [7:0] cnt, input logic mis);
    vec_t v;
    v.r = r; v.ld = ld; v.lv = lv; v.req = req; v.clr = clr;
    v.gnt = gnt; v.en = en; v.crst = crst; v.ui = ui; v.ack = ack;
    v.bsy = bsy; v.sh = sh; v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output.
  task automatic apply(input vec_t v, input int idx);
    rst      = v.r;
    load_req = v.ld;
    load_val = v.lv;
    inc_req  = v.req;
    clr_err  = v.clr;
    @(posedge clk);
    #1;
    chk("inc_gnt",   idx, 32'(inc_gnt),   32'(v.gnt));
    chk("ctr_en",    idx, 32'(ctr_en),    32'(v.en));
    chk("ctr_rst",   idx, 32'(ctr_rst),   32'(v.crst));
    chk("ctr_ui",    idx, 32'(ctr_ui),    32'(v.ui));
    chk("load_ack",  idx, 32'(load_ack),  32'(v.ack));
    chk("busy",      idx, 32'(busy),      32'(v.bsy));
    chk("shadow_v",  idx, 32'(shadow_v),  32'(v.sh));
    chk("grant_cnt", idx, 32'(grant_cnt), 32'(v.cnt));
    chk("mismatch",  idx, 32'(mismatch),  32'(v.mis));
  endtask

  initial begin
    int step;
    checks    = 0;
    errors    = 0;
    dp_v      = 4'd0;
    force_en  = 1'b0;
    force_val = 4'd0;
    rst       = 1'b1;
    load_req  = 1'b0;
    load_val  = 4'd0;
    inc_req   = 4'd0;
    clr_err   = 1'b0;

    //                r     ld    lv     req      clr   gnt      en    crst  ui     ack   bsy   sh     cnt    mis
    // reset two cycles, then one INIT cycle exits to IDLE
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0));
    // load A
    tbl.push_back(mk(1'b0, 1'b1, 4'hA, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 4'h0, 8'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 8'd0, 1'b0));
    // two requesters held: alternating grants, shadow wraps F->0
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 8'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hB, 8'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hC, 8'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hE, 8'd4, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 8'd5, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'd6, 1'b0));
    // load and increment together: load first, grant right after
    tbl.push_back(mk(1'b0, 1'b1, 4'h5, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h0, 8'd6, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 8'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h6, 8'd1, 1'b0));
    // reload 5 ahead of the miscompare sequence
    tbl.push_back(mk(1'b0, 1'b1, 4'h5, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h6, 8'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b0));

    step = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], step);
      step++;
    end

    // Miscompare: set, sticky, clear, set-beats-clear
    force_en  = 1'b1;
    force_val = 4'h3;
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b1), step++);
    force_en  = 1'b0;
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b1), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b0), step++);
    force_en  = 1'b1;
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b1), step++);
    force_en  = 1'b0;
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b1), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 8'd0, 1'b0), step++);

    // Reset in the middle of a four-requester burst; pointer was left at req0
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 8'd0, 1'b0), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h6, 8'd1, 1'b0), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 8'd2, 1'b0), step++);
    apply(mk(1'b1, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0), step++);
    apply(mk(1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 8'd1, 1'b0), step++);

    // Single requester held long enough to saturate the grant counter
    for (int k = 1; k <= 300; k++) begin
      apply(mk(1'b0, 1'b0, 4'h0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1,
               4'(1 + k), (k >= 254) ? 8'd255 : 8'(1 + k), 1'b0), step++);
    end
    apply(mk(1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hE, 8'd255, 1'b0), step++);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
